hdmi_period_sched: RTL and testbench

HDMI_PERIOD_SCHED -- requirements
Module: hdmi_period_sched

---
 rtl/hdmi_period_sched.sv | 206 ++++++++++++++++++++
 tb/tb_hdmi_period_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_period_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdmi_period_sched: HDMI control/preamble/guard/video period scheduler.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hdmi_period_sched #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int MIN_CTRL_LEN = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       de_i,
    input  logic       h_sync_i,
    input  logic       v_sync_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic [1:0] mode_o,
    output logic [3:0] ctl_o,
    output logic [1:0] hv_o,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       err_o
);

    localparam int LAT    = PREAMBLE_LEN + GUARD_LEN + 1;
    localparam int LOW_W  = $clog2(MIN_CTRL_LEN + 1);
    localparam int PH_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int DW     = $clog2(LAT);

    localparam logic [2:0] S_CTRL  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_VID   = 3'd3;
    localparam logic [2:0] S_DROP  = 3'd4;

    localparam logic [1:0] M_CTRL  = 2'd0;
    localparam logic [1:0] M_VID   = 2'd1;
    localparam logic [1:0] M_GUARD = 2'd2;

    localparam logic [LOW_W-1:0] C_LOW_MAX = LOW_W'(MIN_CTRL_LEN);
    localparam logic [PH_W-1:0]  C_PRE_LD  = PH_W'(PREAMBLE_LEN - 1);
    localparam logic [PH_W-1:0]  C_GRD_LD  = PH_W'(GUARD_LEN - 1);
    localparam logic [DW-1:0]    C_DROP_LD = DW'(LAT - 1);

    logic [LAT-1:0]        de_dl_q;
    logic [LAT-1:0][1:0]   hv_dl_q;
    logic [LAT-1:0][23:0]  px_dl_q;

    logic                  de_prev_q;
    logic [LOW_W-1:0]      low_cnt_q, low_cnt_d;
    logic [2:0]            state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic                  pend_q, pend_d;
    logic                  drop_evt_q, drop_evt_d;

    logic [1:0]            mode_q, mode_d;
    logic [3:0]            ctl_q, ctl_d;
    logic [1:0]            hv_q, hv_d;
    logic [23:0]           px_q, px_d;
    logic                  err_q;

    logic                  w_rise, w_elig, w_tap_de;

    assign w_rise   = de_i & ~de_prev_q;
    assign w_elig   = (low_cnt_q >= C_LOW_MAX);
    assign w_tap_de = de_dl_q[LAT-1];

    always_comb begin
        low_cnt_d = low_cnt_q;
        if (de_i) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != C_LOW_MAX) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end
    end

    // A dropped run reaches the delayed tap LAT-1 cycles after its edge;
    // dcnt covers that flight time so DROP only ends on the run's own tail.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dcnt_d     = (dcnt_q != '0) ? dcnt_q - 1'b1 : '0;
        pend_d     = pend_q;
        drop_evt_d = 1'b0;
        if (w_rise && (state_q != S_CTRL || !w_elig)) begin
            drop_evt_d = 1'b1;
            dcnt_d     = C_DROP_LD;
        end
        case (state_q)
            S_CTRL: begin
                if (w_rise && w_elig) begin
                    state_d = S_PRE;
                    phase_d = C_PRE_LD;
                end else if (w_rise) begin
                    state_d = S_DROP;
                end
            end
            S_PRE: begin
                if (w_rise) begin
                    state_d = S_DROP;
                end else if (phase_q == '0) begin
                    state_d = S_GUARD;
                    phase_d = C_GRD_LD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_GUARD: begin
                if (w_rise) begin
                    state_d = S_DROP;
                end else if (phase_q == '0) begin
                    state_d = S_VID;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_VID: begin
                // A dropped edge during VID lets the current run finish first.
                if (w_rise) begin
                    pend_d = 1'b1;
                end
                if (!w_tap_de) begin
                    state_d = (pend_q || w_rise) ? S_DROP : S_CTRL;
                    pend_d  = 1'b0;
                end
            end
            S_DROP: begin
                if (!w_rise && dcnt_q == '0 && !w_tap_de) begin
                    state_d = S_CTRL;
                end
            end
            default: begin
                state_d = S_CTRL;
            end
        endcase
    end

    always_comb begin
        mode_d = M_CTRL;
        ctl_d  = 4'b0000;
        px_d   = '0;
        hv_d   = hv_dl_q[LAT-1];
        case (state_q)
            S_PRE:   ctl_d  = 4'b0001;
            S_GUARD: mode_d = M_GUARD;
            S_VID: begin
                if (w_tap_de) begin
                    mode_d = M_VID;
                    px_d   = px_dl_q[LAT-1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            de_dl_q    <= '0;
            hv_dl_q    <= '0;
            px_dl_q    <= '0;
            de_prev_q  <= 1'b0;
            low_cnt_q  <= C_LOW_MAX;
            state_q    <= S_CTRL;
            phase_q    <= '0;
            dcnt_q     <= '0;
            pend_q     <= 1'b0;
            drop_evt_q <= 1'b0;
            mode_q     <= M_CTRL;
            ctl_q      <= 4'b0000;
            hv_q       <= 2'b00;
            px_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            de_dl_q    <= {de_dl_q[LAT-2:0], de_i};
            hv_dl_q    <= {hv_dl_q[LAT-2:0], {v_sync_i, h_sync_i}};
            px_dl_q    <= {px_dl_q[LAT-2:0], {red_i, green_i, blue_i}};
            de_prev_q  <= de_i;
            low_cnt_q  <= low_cnt_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            dcnt_q     <= dcnt_d;
            pend_q     <= pend_d;
            drop_evt_q <= drop_evt_d;
            mode_q     <= mode_d;
            ctl_q      <= ctl_d;
            hv_q       <= hv_d;
            px_q       <= px_d;
            err_q      <= drop_evt_q;
        end
    end

    assign mode_o  = mode_q;
    assign ctl_o   = ctl_q;
    assign hv_o    = hv_q;
    assign red_o   = px_q[23:16];
    assign green_o = px_q[15:8];
    assign blue_o  = px_q[7:0];
    assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_period_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hdmi_period_sched: self-checking bench for hdmi_period_sched.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hdmi_period_sched;

    localparam int P = 8;
    localparam int G = 2;
    localparam int M = 12;
    localparam int L = P + G + 1;
    localparam int N = 1024;

    logic       clk;
    logic       rst;
    logic       de, hs, vs;
    logic [7:0] r_in, g_in, b_in;
    logic [1:0] mode_o, hv_o;
    logic [3:0] ctl_o;
    logic [7:0] red_o, green_o, blue_o;
    logic       err_o;

    hdmi_period_sched #(
        .PREAMBLE_LEN(P),
        .GUARD_LEN   (G),
        .MIN_CTRL_LEN(M)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .de_i    (de),
        .h_sync_i(hs),
        .v_sync_i(vs),
        .red_i   (r_in),
        .green_i (g_in),
        .blue_i  (b_in),
        .mode_o  (mode_o),
        .ctl_o   (ctl_o),
        .hv_o    (hv_o),
        .red_o   (red_o),
        .green_o (green_o),
        .blue_o  (blue_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus plan, one entry per clock edge of a phase
    bit          in_de  [N];
    logic [1:0]  in_hv  [N];
    logic [23:0] in_pix [N];
    int          pos;

    // expected outputs after each edge
    logic [1:0]  exp_mode [N];
    logic [3:0]  exp_ctl  [N];
    logic [1:0]  exp_hv   [N];
    logic [23:0] exp_pix  [N];
    logic        exp_err  [N];

    // observed outputs after each edge
    logic [1:0]  obs_mode [N];
    logic [3:0]  obs_ctl  [N];
    logic [1:0]  obs_hv   [N];
    logic [7:0]  obs_red  [N];
    logic        obs_err  [N];

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] dut_vec();
        return {mode_o, ctl_o, hv_o, red_o, green_o, blue_o, err_o};
    endfunction

    task automatic plan_clear();
        pos = 0;
        for (int i = 0; i < N; i++) begin
            in_de[i]  = 1'b0;
            in_hv[i]  = 2'b00;
            in_pix[i] = '0;
        end
    endtask

    // blanking: sync lines may toggle, pixel bus carries junk that must never appear
    task automatic add_low(input int n, input bit toggle_hv);
        for (int i = 0; i < n; i++) begin
            in_de[pos]  = 1'b0;
            in_hv[pos]  = toggle_hv ? 2'($urandom_range(0, 3)) : 2'b00;
            in_pix[pos] = 24'($urandom);
            pos++;
        end
    endtask

    task automatic add_px(input logic [23:0] px);
        in_de[pos]  = 1'b1;
        in_hv[pos]  = 2'($urandom_range(0, 3));
        in_pix[pos] = px;
        pos++;
    endtask

    task automatic add_run(input int len);
        for (int i = 0; i < len; i++) add_px(24'($urandom));
    endtask

    // Reference: an edge after >= M low samples opens a period (P preamble,
    // G guard, then every pixel of the run at +L); any other edge is dropped
    // with a one-cycle error flag. Sync lines are a pure L-cycle delay.
    task automatic model(input int n);
        int low;
        bit prev;
        low  = M;
        prev = 1'b0;
        for (int t = 0; t < N; t++) begin
            exp_mode[t] = 2'd0;
            exp_ctl[t]  = 4'd0;
            exp_hv[t]   = 2'd0;
            exp_pix[t]  = '0;
            exp_err[t]  = 1'b0;
        end
        for (int j = 0; j < n; j++) begin
            if (in_de[j] && !prev) begin
                if (low >= M) begin
                    for (int t = 1; t <= P; t++) exp_ctl[j + t] = 4'b0001;
                    for (int t = P + 1; t <= P + G; t++) exp_mode[j + t] = 2'd2;
                    for (int m = j; m < n && in_de[m]; m++) begin
                        exp_mode[m + L] = 2'd1;
                        exp_pix[m + L]  = in_pix[m];
                    end
                end else begin
                    exp_err[j + 1] = 1'b1;
                end
            end
            low  = in_de[j] ? 0 : ((low < M) ? low + 1 : M);
            prev = in_de[j];
        end
        for (int t = L; t < n + L; t++) exp_hv[t] = in_hv[t - L];
    endtask

    task automatic drive(input int c);
        de = in_de[c];
        {vs, hs} = in_hv[c];
        {r_in, g_in, b_in} = in_pix[c];
    endtask

    task automatic run_phase(input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            if (c > 0) begin
                obs_mode[c-1] = mode_o;
                obs_ctl[c-1]  = ctl_o;
                obs_hv[c-1]   = hv_o;
                obs_red[c-1]  = red_o;
                obs_err[c-1]  = err_o;
                chk($sformatf("cyc%0d", c - 1), dut_vec(),
                    {exp_mode[c-1], exp_ctl[c-1], exp_hv[c-1], exp_pix[c-1], exp_err[c-1]});
            end
            if (c < ncyc) drive(c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", dut_vec(), 33'd0);
        rst = 1'b0;
    endtask

    int k;
    int n;
    int err_seen;
    int gaps [4] = '{12, 11, 12, 11};

    initial begin
        rst = 1'b1;
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;

        // Phase 1: basic 4-pixel period after 20 blanking cycles
        do_reset();
        plan_clear();
        add_low(20, 1'b1);
        k = pos;
        add_px(24'h111111);
        add_px(24'h222222);
        add_px(24'h333333);
        add_px(24'h444444);
        add_low(20, 1'b1);
        n = pos;
        model(n);
        run_phase(n + L + 2);
        for (int t = 1; t <= P; t++) chk("pre_ctl", 33'(obs_ctl[k + t]), 33'h1);
        chk("pre_mode", 33'(obs_mode[k + 1]), 33'd0);
        chk("guard_mode0", 33'(obs_mode[k + 9]), 33'd2);
        chk("guard_mode1", 33'(obs_mode[k + 10]), 33'd2);
        chk("guard_ctl", 33'(obs_ctl[k + 10]), 33'd0);
        chk("vid_px0", {31'(obs_red[k + 11]), obs_mode[k + 11]}, {31'h11, 2'd1});
        chk("vid_px1", {31'(obs_red[k + 12]), obs_mode[k + 12]}, {31'h22, 2'd1});
        chk("vid_px2", {31'(obs_red[k + 13]), obs_mode[k + 13]}, {31'h33, 2'd1});
        chk("vid_px3", {31'(obs_red[k + 14]), obs_mode[k + 14]}, {31'h44, 2'd1});
        chk("post_ctrl", {31'(obs_red[k + 15]), obs_mode[k + 15]}, 33'd0);
        chk("hv_delay", 33'(obs_hv[k + 5]), 33'(in_hv[k + 5 - L]));
        err_seen = 0;
        for (int t = 0; t < n + L; t++) err_seen += int'(obs_err[t]);
        chk("no_err", 33'(err_seen), 33'd0);

        // Phase 2: gaps of 12 / 11 then randomized run lengths and gaps
        do_reset();
        plan_clear();
        add_low(20, 1'b1);
        for (int i = 0; i < 14; i++) begin
            add_run($urandom_range(1, 6));
            if (i < 4) add_low(gaps[i], 1'b1);
            else add_low($urandom_range(0, 2) == 0 ? 11 : 12 + $urandom_range(0, 5), 1'b1);
        end
        n = pos;
        model(n);
        run_phase(n + L + 2);
        err_seen = 0;
        for (int t = 0; t < n + L; t++) err_seen += int'(obs_err[t]);
        chk("err_pulses_min", 33'(err_seen >= 2), 33'd1);

        // Phase 3: reset asserted while the second pixel of a run is on the outputs
        do_reset();
        plan_clear();
        add_low(20, 1'b1);
        k = pos;
        add_run(5);
        add_low(20, 1'b1);
        n = pos;
        model(n);
        run_phase(k + L + 2);
        chk("vid_before_abort", 33'(obs_mode[k + L + 1]), 33'd1);
        #2 rst = 1'b1;
        #1 chk("async_abort", dut_vec(), 33'd0);

        // Phase 4: single-pixel run after a fresh release
        do_reset();
        plan_clear();
        add_low(20, 1'b1);
        k = pos;
        add_px(24'($urandom) | 24'h010101);
        add_low(20, 1'b1);
        n = pos;
        model(n);
        run_phase(n + L + 2);
        chk("sp_pre_first", 33'(obs_ctl[k + 1]), 33'h1);
        chk("sp_pre_last", 33'(obs_ctl[k + P]), 33'h1);
        chk("sp_guard", {31'(obs_mode[k + 9]), obs_mode[k + 10]}, {31'd2, 2'd2});
        chk("sp_vid", 33'(obs_mode[k + 11]), 33'd1);
        chk("sp_vid_px", 33'(obs_red[k + 11]), 33'(in_pix[k][23:16]));
        chk("sp_after", 33'(obs_mode[k + 12]), 33'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
